// File: rtl/sync_fifo_rd_stream_pkg.sv
// Shared types and helpers for the FIFO read-side stream adapter.
package sync_fifo_rd_stream_pkg;

    localparam int LEVEL_W = 2;
    localparam logic [LEVEL_W-1:0] OCC_FULL = 2'd2;

    typedef enum logic [1:0] {
        CAP_NONE = 2'd0,
        CAP_HEAD = 2'd1,
        CAP_SKID = 2'd2
    } cap_sel_e;

    // Buffer demand at 3 bits so the subtraction never wraps.
    function automatic logic [2:0] demand(
        input logic [LEVEL_W-1:0] occ,
        input logic               inflight,
        input logic               pop
    );
        return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/sync_fifo_rd_stream_buf2.sv
// Two-entry ordered buffer: head is always the oldest word,
// skid holds the second one.
module stream_buf2
    import sync_fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [LEVEL_W-1:0]    o_occ
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_skid;
    logic [LEVEL_W-1:0]    r_occ;

    logic                  w_pop;
    logic [LEVEL_W-1:0]    w_after;
    logic [LEVEL_W-1:0]    w_occ_nxt;
    cap_sel_e              w_cap;

    assign w_pop     = i_pop & (r_occ != '0);
    assign w_after   = r_occ - {1'b0, w_pop};
    assign w_occ_nxt = w_after + {1'b0, i_push};

    always_comb begin
        w_cap = CAP_NONE;
        if (i_push) begin
            if (w_after == '0) begin
                w_cap = CAP_HEAD;
            end else begin
                w_cap = CAP_SKID;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_skid <= '0;
            r_occ  <= '0;
        end else begin
            r_occ <= w_occ_nxt;
            if (w_pop && (r_occ == OCC_FULL)) begin
                r_head <= r_skid;
            end
            unique case (w_cap)
                CAP_HEAD: r_head <= i_din;
                CAP_SKID: r_skid <= i_din;
                default: ;
            endcase
        end
    end

    assign o_head = r_head;
    assign o_occ  = r_occ;

endmodule

// File: rtl/sync_fifo_rd_stream.sv
// Drains a 1-cycle-latency FIFO read port into a registered
// valid/ready stream without over-reading or dropping words.
module sync_fifo_rd_stream
    import sync_fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [LEVEL_W-1:0]    m_level
);

    logic                  r_inflight;
    logic                  w_pop;
    logic [LEVEL_W-1:0]    w_occ;
    logic [2:0]            w_demand;
    logic [DATA_WIDTH-1:0] w_head;

    assign m_valid  = (w_occ != '0);
    assign w_pop    = m_valid & m_ready;
    assign w_demand = demand(w_occ, r_inflight, w_pop);

    // Only read when the returning word is guaranteed a slot.
    assign fifo_rd_en = ~rst & ~fifo_empty & (w_demand < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
        end
    end

    stream_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_inflight),
        .i_pop  (w_pop),
        .i_din  (fifo_data),
        .o_head (w_head),
        .o_occ  (w_occ)
    );

    assign m_data  = w_head;
    assign m_level = w_occ;

    always @(posedge clk) begin
        if (!rst) begin
            assert (({1'b0, w_occ} + {2'b00, r_inflight}) <= 3'd2)
            else $error("occ + inflight exceeds 2");
            assert (!(r_inflight && (w_occ == OCC_FULL) && !w_pop))
            else $error("capture into full buffer");
        end
    end

endmodule
